led_pulse_stretcher: RTL



---
 rtl/led_pulse_stretcher_pkg.sv | 31 +++
 rtl/led_pulse_stretcher_edge.sv | 31 +++
 rtl/led_pulse_stretcher.sv | 135 +++++++++++++
 3 files changed

// File: rtl/led_pulse_stretcher_pkg.sv
// -----------------------------------------------------------------------------
// led_pulse_stretcher_pkg
// Shared definitions for the LED pulse stretcher and other board-level blocks:
//   - state encoding for the stretcher FSM
//   - board clock frequency and millisecond-to-cycle conversion constants
// -----------------------------------------------------------------------------
package led_pulse_stretcher_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_ON   = 2'd1;
    localparam logic [1:0] ST_GAP  = 2'd2;

    typedef enum logic [1:0] {
        S_IDLE = ST_IDLE,
        S_ON   = ST_ON,
        S_GAP  = ST_GAP
    } state_t;

    localparam int CLK_FREQ_HZ      = 25_000_000;
    localparam int CYCLES_PER_MS    = CLK_FREQ_HZ / 1000;
    localparam int DEFAULT_BLINK_MS = 100;
    localparam int DEFAULT_GAP_MS   = 100;

    function automatic int ms_to_cycles(input int ms);
        return ms * CYCLES_PER_MS;
    endfunction

    localparam int DEFAULT_BLINK_CYCLES = DEFAULT_BLINK_MS * CYCLES_PER_MS;
    localparam int DEFAULT_GAP_CYCLES   = DEFAULT_GAP_MS * CYCLES_PER_MS;

endpackage

// File: rtl/led_pulse_stretcher_edge.sv
// -----------------------------------------------------------------------------
// event_edge_detect
// Rising-edge detector for a signal already synchronous to CLK.
// Ports:
//   CLK   in   system clock
//   RST   in   asynchronous, active-high reset
//   IN    in   level input
//   RISE  out  high for the cycle in which IN is high and was low last cycle
// -----------------------------------------------------------------------------
module event_edge_detect
    import led_pulse_stretcher_pkg::*;
(
    input  logic CLK,
    input  logic RST,
    input  logic IN,
    output logic RISE
);

    logic in_q;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            in_q <= 1'b0;
        end else begin
            in_q <= IN;
        end
    end

    assign RISE = IN & ~in_q;

endmodule

// File: rtl/led_pulse_stretcher.sv
// -----------------------------------------------------------------------------
// led_pulse_stretcher
// Turns short internal events into human-visible LED blinks: each accepted
// event gives ON_CYCLES of LED high followed by OFF_CYCLES of dark gap.
// Events arriving during a blink are queued in a saturating pending counter.
//
// Optional feature macro: LED_PULSE_EVENT_EDGE_EN
//   defined   - an event is the rising edge of EVENT (one per press)
//   undefined - every cycle EVENT is high is a separate event
//
// Ports:
//   CLK      in   system clock
//   RST      in   asynchronous, active-high reset
//   EVENT    in   event request, synchronous to CLK
//   LED      out  stretched pulse, active-high (registered)
//   BUSY     out  high whenever the FSM is not idle (registered)
//   PENDING  out  queued blinks not yet started (registered, saturating)
//
// state  | meaning
// -------+---------------------------------------------------------
// S_IDLE | no blink in progress, waiting for an event
// S_ON   | LED high, timer counting down ON_CYCLES
// S_GAP  | LED low, timer counting down OFF_CYCLES, then next/idle
// -----------------------------------------------------------------------------
module led_pulse_stretcher
    import led_pulse_stretcher_pkg::*;
#(
    parameter int ON_CYCLES  = DEFAULT_BLINK_CYCLES,
    parameter int OFF_CYCLES = DEFAULT_GAP_CYCLES,
    parameter int PEND_WIDTH = 3
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  EVENT,
    output logic                  LED,
    output logic                  BUSY,
    output logic [PEND_WIDTH-1:0] PENDING
);

    localparam int MAX_CYCLES = (ON_CYCLES > OFF_CYCLES) ? ON_CYCLES : OFF_CYCLES;
    localparam int TW         = $clog2(MAX_CYCLES) + 1;

    // Timer counts down to zero; zero marks the last cycle of the phase.
    localparam logic [TW-1:0]         ON_LOAD  = TW'(ON_CYCLES - 1);
    localparam logic [TW-1:0]         OFF_LOAD = TW'(OFF_CYCLES - 1);
    localparam logic [PEND_WIDTH-1:0] PEND_MAX = '1;

    state_t        state;
    logic [TW-1:0] timer;
    logic          ev;
    logic          timer_done;
    logic          pend_full;
    logic          pend_nonzero;

`ifdef LED_PULSE_EVENT_EDGE_EN
    event_edge_detect u_edge (
        .CLK  (CLK),
        .RST  (RST),
        .IN   (EVENT),
        .RISE (ev)
    );
`else
    assign ev = EVENT;
`endif

    assign timer_done   = (timer == '0);
    assign pend_full    = (PENDING == PEND_MAX);
    assign pend_nonzero = (PENDING != '0);

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state   <= S_IDLE;
            LED     <= 1'b0;
            BUSY    <= 1'b0;
            PENDING <= '0;
            timer   <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (ev) begin
                        state <= S_ON;
                        LED   <= 1'b1;
                        BUSY  <= 1'b1;
                        timer <= ON_LOAD;
                    end
                end

                S_ON: begin
                    if (ev && !pend_full) begin
                        PENDING <= PENDING + PEND_WIDTH'(1);
                    end
                    if (timer_done) begin
                        state <= S_GAP;
                        LED   <= 1'b0;
                        timer <= OFF_LOAD;
                    end else begin
                        timer <= timer - TW'(1);
                    end
                end

                S_GAP: begin
                    if (timer_done) begin
                        if (pend_nonzero || ev) begin
                            state <= S_ON;
                            LED   <= 1'b1;
                            timer <= ON_LOAD;
                            // A same-cycle event replaces the dequeued one, so
                            // the count only drops when no event arrives.
                            if (pend_nonzero && !ev) begin
                                PENDING <= PENDING - PEND_WIDTH'(1);
                            end
                        end else begin
                            state <= S_IDLE;
                            BUSY  <= 1'b0;
                        end
                    end else begin
                        timer <= timer - TW'(1);
                        if (ev && !pend_full) begin
                            PENDING <= PENDING + PEND_WIDTH'(1);
                        end
                    end
                end

                default: begin
                    state   <= S_IDLE;
                    LED     <= 1'b0;
                    BUSY    <= 1'b0;
                    PENDING <= '0;
                    timer   <= '0;
                end
            endcase
        end
    end

endmodule
